ip_mem_arb_rr2: RTL
===================

Name: ip_mem_arb_rr2

Overview:
- Shares one single-port, flop-in/flop-out memory (read latency RD_LAT) between two DMA requesters (A, B) and a low-priority CPU port.
- A and B are arbitrated round-robin with a bounded burst hold.
- The CPU is served in idle slots, or is forced in after a starvation limit.
- Read returns are tagged by source and pipelined back to the issuing port.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 16, memory data width
RD_LAT, 2, cycles from enable&~wr to valid memory rdData (min 1)
MAX_BURST, 4, max consecutive grants to one DMA port while the other requests (min 1)
STARVE_LIM, 16, wait cycles after which the pending CPU access preempts DMA (min 1)

Ports:
clockCore in 1 clock; all logic rising-edge
resetCore in 1 asynchronous, active-low reset
aReq in 1 port A access request, level
aRd in 1 port A 1=read 0=write, valid with aReq
aAddr in ADDR_WIDTH port A address
aWrData in DATA_WIDTH port A write data
aGnt out 1 port A access accepted this cycle (combinational)
aRdVld out 1 port A read data valid, 1-cycle pulse
aRdData out DATA_WIDTH port A read data, valid with aRdVld
bReq, bRd, bAddr, bWrData, bGnt, bRdVld, bRdData: as port A, for port B
cpuMemReq in 1 CPU request; rising edge starts one access
cpuMemRd in 1 CPU 1=read, sampled at edge
cpuMemAddr in ADDR_WIDTH CPU address, sampled at edge
cpuMemWrData in DATA_WIDTH CPU write data, sampled at edge
cpuMemAck out 1 CPU completion pulse, registered
cpuMemRdData out DATA_WIDTH CPU read data, registered, valid with ack, held after
enable out 1 memory enable
wr out 1 memory write strobe
addr out ADDR_WIDTH memory address
wrData out DATA_WIDTH memory write data
rdData in DATA_WIDTH memory read data

Behaviour:
- Reset (resetCore low, asynchronous):
  - aRdVld, bRdVld, cpuMemAck low; cpuMemRdData 0.
  - Tag pipe cleared, so in-flight reads are dropped and no rdVld appears after reset.
  - CPU pending cleared; starve counter 0; burst counter 0.
  - rrLast=B, so A wins the first contention.
- Transfer rule: a transfer occurs in the cycle with xReq&xGnt.
  - Exactly one of aGnt, bGnt, cpuGrant is high in any cycle, or none.
  - enable = any grant.
  - wr, addr, wrData are muxed combinationally from the granted source.
  - The CPU source uses the values captured at its request edge.
- Owner state machine:
  - States: IDLE, OWN_A, OWN_B, CPU.
  - Evaluated each cycle; the next state is registered.
- DMA selection:
  - Only one DMA port requesting: that port is granted.
  - Both requesting and the current owner has burstCnt < MAX_BURST: the owner keeps the grant.
  - Otherwise the grant goes to the port that is not rrLast.
- Burst counter:
  - Increments on each owner grant while the other port requests.
  - Resets to 1 on an owner change; cleared when the other port is idle.
  - rrLast updates to the granted port.
- CPU pending:
  - Set on a registered rising edge of cpuMemReq.
  - Address, data and rd are captured at that edge.
  - Further edges while pending or in flight are ignored.
- CPU grant occurs when either:
  - pending and no DMA request exists, or
  - pending and starveCnt == STARVE_LIM. This slot preempts DMA; aGnt and bGnt are low that cycle.
- Starve counter:
  - Increments each cycle the CPU is pending and not granted; saturates at STARVE_LIM.
  - Clears on CPU grant.
- CPU grant effects: the CPU grant clears pending. The DMA burst counter and rrLast are unchanged by a CPU slot.
- Read return:
  - Each read grant pushes {valid, src[1:0]} into an RD_LAT-deep shift register.
  - At the output, src A asserts aRdVld and src B asserts bRdVld; aRdData and bRdData both equal rdData.
  - A DMA read granted at cycle t yields its rdVld at t+RD_LAT.
  - src CPU registers rdData into cpuMemRdData; cpuMemAck pulses at t+RD_LAT+1.
- CPU write: cpuMemAck pulses at t+1.
- Back-to-back: reads can be granted every cycle; returns stay in order with no bubbles.
- Read-after-write to the same address: no forwarding. Memory ordering suffices because accesses are serialized.

Decomposition:
- Package ip_mem_arb_pkg holds:
  - source encoding SRC_NONE=0, SRC_A=1, SRC_B=2, SRC_CPU=3;
  - owner state encoding;
  - counter width helper clog2(MAX_BURST+1), clog2(STARVE_LIM+1).
- Sub-module ip_mem_rd_tag_pipe holds the parameterised RD_LAT shift register of {valid, src}, with async reset.

Test Plan:
- Reset, then aReq=1 aRd=0 addr 0x10 data 0x1234 for 1 cycle, then an A read of 0x10 -> aGnt both cycles; aRdVld exactly 2 cycles after the read grant with aRdData=0x1234; bRdVld stays 0.
- aReq and bReq held high with reads, MAX_BURST=4 -> grant pattern AAAABBBBAAAA; each rdVld goes only to its issuer, in order, 2 cycles after grant.
- CPU read edge at 0x20 while A and B are continuously busy, STARVE_LIM=16 -> CPU slot in the 17th cycle after pending (starveCnt reaches 16); cpuMemAck pulses 3 cycles after the slot with the stored 0x20 data; DMA resumes with the same owner and burst count.
- CPU write edge with both DMA ports idle -> enable&wr in the next cycle, cpuMemAck 1 cycle later; a second edge while in flight -> no second access.
- Read granted, then resetCore pulsed low 1 cycle later -> no aRdVld and no cpuMemAck after reset; first contention after reset goes to A.

Source files
------------

// File: rtl/ip_mem_arb_pkg.sv
// ip_mem_arb_pkg: shared types and helpers for the ip_mem_arb_rr2 memory arbiter.
//   src_e    - 2-bit access source tag carried alongside reads.
//   own_e    - owner state of the arbitration FSM.
//   rd_tag_t - {valid, src} entry of the read-return tag pipe.
//   cnt_w()  - width of a counter that must hold values 0..max_val.
package ip_mem_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_CPU  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    CPU   = 2'd3
  } own_e;

  typedef struct packed {
    logic vld;
    src_e src;
  } rd_tag_t;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ip_mem_rd_tag_pipe.sv
// ip_mem_rd_tag_pipe: RD_LAT-deep shift register of {valid, src} tags that
// tracks reads in flight through the memory so each return can be steered
// back to its issuer.
//   clockCore    - clock, rising edge
//   resetCore    - asynchronous active-low reset; drops all in-flight tags
//   push         - tag for the access issued this cycle (vld=0 if no read)
//   pop          - tag whose read data is on the memory rdData bus this cycle
//   cpu_inflight - some stage holds a valid CPU read
module ip_mem_rd_tag_pipe
  import ip_mem_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clockCore,
  input  logic    resetCore,
  input  rd_tag_t push,
  output rd_tag_t pop,
  output logic    cpu_inflight
);

  rd_tag_t [RD_LAT-1:0] stage;
  logic    [RD_LAT-1:0] is_cpu;

  if (RD_LAT == 1) begin : g_one
    always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) stage <= '0;
      else            stage <= push;
    end
  end else begin : g_many
    always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) stage <= '0;
      else            stage <= {stage[RD_LAT-2:0], push};
    end
  end

  for (genvar i = 0; i < RD_LAT; i++) begin : g_cpu
    assign is_cpu[i] = stage[i].vld && (stage[i].src == SRC_CPU);
  end

  assign pop          = stage[RD_LAT-1];
  assign cpu_inflight = |is_cpu;

endmodule

// File: rtl/ip_mem_arb_rr2.sv
// ip_mem_arb_rr2: shares one single-port flop-in/flop-out memory between two
// DMA ports (A, B) and a low-priority CPU port.
//   A/B    : round-robin with a bounded burst hold (MAX_BURST grants while the
//            other port waits). xGnt is combinational; a transfer happens in
//            any cycle with xReq & xGnt. Read data returns on xRdVld RD_LAT
//            cycles after the grant.
//   CPU    : a registered rising edge of cpuMemReq captures rd/addr/data and
//            makes one access pending. It is served in a slot with no DMA
//            request, or forced in once it has waited STARVE_LIM cycles.
//            cpuMemAck pulses one cycle after a write slot, RD_LAT+1 cycles
//            after a read slot, with cpuMemRdData registered (and held).
//   Memory : enable/wr/addr/wrData muxed from the granted source; rdData in.
module ip_mem_arb_rr2
  import ip_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LAT     = 2,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  input  logic                  aReq,
  input  logic                  aRd,
  input  logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0] aWrData,
  output logic                  aGnt,
  output logic                  aRdVld,
  output logic [DATA_WIDTH-1:0] aRdData,
  input  logic                  bReq,
  input  logic                  bRd,
  input  logic [ADDR_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0] bWrData,
  output logic                  bGnt,
  output logic                  bRdVld,
  output logic [DATA_WIDTH-1:0] bRdData,
  input  logic                  cpuMemReq,
  input  logic                  cpuMemRd,
  input  logic [ADDR_WIDTH-1:0] cpuMemAddr,
  input  logic [DATA_WIDTH-1:0] cpuMemWrData,
  output logic                  cpuMemAck,
  output logic [DATA_WIDTH-1:0] cpuMemRdData,
  output logic                  enable,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wrData,
  input  logic [DATA_WIDTH-1:0] rdData
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int SW = cnt_w(STARVE_LIM);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIM);

  // ---------------------------------------------------------------- state
  own_e            state, state_nxt;
  logic            rr_last_b, rr_nxt;     // last DMA grant went to B
  logic [BW-1:0]   burst_cnt, burst_nxt;
  logic            own_hold;              // a DMA owner existed before the CPU slot
  logic [SW-1:0]   starve_cnt;

  logic            cpu_req_q, cpu_pend, cpu_rd_q;
  logic [ADDR_WIDTH-1:0] cpu_addr_q;
  logic [DATA_WIDTH-1:0] cpu_wdata_q;

  logic            a_gnt, b_gnt, cpu_gnt;
  logic            owner_vld, owner_b, pick_b;
  logic            cpu_edge, cpu_busy, cpu_ret, cpu_in_pipe;

  rd_tag_t         tag_push, tag_pop;

  // -------------------------------------------------- owner FSM, next state
  // The DMA owner is the port of the last DMA grant. In CPU state it is
  // remembered through rr_last_b so a forced CPU slot does not break a burst;
  // own_hold keeps an idle-slot CPU access from inventing an owner.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    cpu_gnt   = 1'b0;
    pick_b    = 1'b0;
    state_nxt = IDLE;
    rr_nxt    = rr_last_b;
    burst_nxt = burst_cnt;
    owner_vld = 1'b0;
    owner_b   = rr_last_b;

    unique case (state)
      OWN_A:   begin owner_vld = 1'b1; owner_b = 1'b0; end
      OWN_B:   begin owner_vld = 1'b1; owner_b = 1'b1; end
      CPU:     owner_vld = own_hold;
      default: ;
    endcase

    if (cpu_pend && ((starve_cnt == SLIM) || !(aReq || bReq))) begin
      cpu_gnt   = 1'b1;
      state_nxt = CPU;
    end else if (aReq || bReq) begin
      if (aReq && bReq) begin
        if (owner_vld && (burst_cnt < MAX_B)) pick_b = owner_b;
        else                                  pick_b = ~rr_last_b;
      end else begin
        pick_b = bReq;
      end
      a_gnt     = ~pick_b;
      b_gnt     = pick_b;
      state_nxt = pick_b ? OWN_B : OWN_A;
      rr_nxt    = pick_b;
      // Burst length only counts grants made while the other port waits.
      if (!(aReq && bReq))                    burst_nxt = '0;
      else if (owner_vld && pick_b == owner_b) burst_nxt = burst_cnt + 1'b1;
      else                                    burst_nxt = BW'(1);
    end
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state     <= IDLE;
      rr_last_b <= 1'b1;
      burst_cnt <= '0;
      own_hold  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_last_b <= rr_nxt;
      burst_cnt <= burst_nxt;
      if (state_nxt != CPU) own_hold <= (state_nxt == OWN_A) || (state_nxt == OWN_B);
    end
  end

  // ------------------------------------------------------------ CPU port
  // One CPU access at a time: edges are ignored from capture until the ack
  // pulse has been delivered.
  assign cpu_busy = cpu_pend | cpu_in_pipe | cpuMemAck;
  assign cpu_edge = cpuMemReq & ~cpu_req_q & ~cpu_busy;

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      cpu_req_q   <= 1'b0;
      cpu_pend    <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      starve_cnt  <= '0;
    end else begin
      cpu_req_q <= cpuMemReq;
      if (cpu_edge) begin
        cpu_pend    <= 1'b1;
        cpu_rd_q    <= cpuMemRd;
        cpu_addr_q  <= cpuMemAddr;
        cpu_wdata_q <= cpuMemWrData;
      end else if (cpu_gnt) begin
        cpu_pend <= 1'b0;
      end
      if (cpu_gnt || !cpu_pend)  starve_cnt <= '0;
      else if (starve_cnt != SLIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------ memory datapath
  assign aGnt   = a_gnt;
  assign bGnt   = b_gnt;
  assign enable = a_gnt | b_gnt | cpu_gnt;

  always_comb begin
    wr       = 1'b0;
    addr     = '0;
    wrData   = '0;
    tag_push = '{vld: 1'b0, src: SRC_NONE};
    if (a_gnt) begin
      wr = ~aRd;  addr = aAddr;  wrData = aWrData;  tag_push.src = SRC_A;
    end else if (b_gnt) begin
      wr = ~bRd;  addr = bAddr;  wrData = bWrData;  tag_push.src = SRC_B;
    end else if (cpu_gnt) begin
      wr = ~cpu_rd_q;  addr = cpu_addr_q;  wrData = cpu_wdata_q;  tag_push.src = SRC_CPU;
    end
    tag_push.vld = (a_gnt & aRd) | (b_gnt & bRd) | (cpu_gnt & cpu_rd_q);
  end

  // --------------------------------------------------------- read return
  ip_mem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clockCore    (clockCore),
    .resetCore    (resetCore),
    .push         (tag_push),
    .pop          (tag_pop),
    .cpu_inflight (cpu_in_pipe)
  );

  assign aRdVld  = tag_pop.vld && (tag_pop.src == SRC_A);
  assign bRdVld  = tag_pop.vld && (tag_pop.src == SRC_B);
  assign aRdData = rdData;
  assign bRdData = rdData;
  assign cpu_ret = tag_pop.vld && (tag_pop.src == SRC_CPU);

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      cpuMemAck    <= 1'b0;
      cpuMemRdData <= '0;
    end else begin
      cpuMemAck <= cpu_ret | (cpu_gnt & ~cpu_rd_q);
      if (cpu_ret) cpuMemRdData <= rdData;
    end
  end

endmodule
